// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: NUM_REGS 32-bit software-writable control registers
// with byte-enable writes, readback, per-register write strobes and optional
// self-clearing (pulse) registers. Single clock domain (OPB_Clk).
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]          C_BASEADDR     = 32'h01010400,
  parameter logic [31:0]          C_HIGHADDR     = 32'h010104FF,
  parameter int unsigned          C_OPB_AWIDTH   = 32,
  parameter int unsigned          C_OPB_DWIDTH   = 32,
  parameter int unsigned          NUM_REGS       = 4,
  parameter logic [31:0]          C_RESET_VAL    = 32'h00000000,
  parameter logic [NUM_REGS-1:0]  C_SELFCLR_MASK = '0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:31]               OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:31]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*NUM_REGS-1:0]    user_data_out,
  output logic [NUM_REGS-1:0]       user_wr_stb
);

  localparam int unsigned DW    = 32;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned IDX_W = 30;

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic                ack_q, ack_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [NUM_REGS-1:0] stb_q, stb_d;

  // OPB big-endian vectors assigned positionally: DBus[0] lands on bit 31.
  logic [DW-1:0]    addr_c, wdata_c, offset_c;
  logic [NB-1:0]    be_c;
  logic [IDX_W-1:0] idx_c;
  logic             hit_c, idx_ok_c;
  logic             unused_ok;

  assign addr_c   = OPB_ABus;
  assign wdata_c  = OPB_DBus;
  assign be_c     = OPB_BE;
  assign offset_c = addr_c - C_BASEADDR;
  assign idx_c    = offset_c[DW-1:2];
  assign idx_ok_c = idx_c < IDX_W'(NUM_REGS);

  // A new transfer is only accepted while no acknowledge is outstanding.
  assign hit_c = OPB_select && (addr_c >= C_BASEADDR) && (addr_c <= C_HIGHADDR) && !ack_q;

  assign unused_ok = ^{OPB_seqAddr, offset_c[1:0], C_OPB_AWIDTH[0], C_OPB_DWIDTH[0]};

  // Next-state: register updates, self-clear, strobes, read mux and ack.
  always_comb begin
    ack_d   = hit_c;
    rdata_d = '0;
    stb_d   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (C_SELFCLR_MASK[i] && stb_q[i]) ? '0 : regs_q[i];
      if (hit_c && idx_ok_c && (idx_c == IDX_W'(i))) begin
        if (!OPB_RNW) begin
          for (int j = 0; j < NB; j++) begin
            if (be_c[j]) regs_d[i][8*j +: 8] = wdata_c[8*j +: 8];
          end
          stb_d[i] = 1'b1;
        end else begin
          rdata_d = regs_q[i];
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      stb_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= C_RESET_VAL;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      stb_q   <= stb_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Flatten the register array onto the fabric-facing bus.
  always_comb begin
    user_data_out = '0;
    for (int i = 0; i < NUM_REGS; i++) user_data_out[32*i +: 32] = regs_q[i];
  end

  assign Sl_DBus     = rdata_q;
  assign Sl_xferAck  = ack_q;
  assign user_wr_stb = stb_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed, table-driven bench for opb_register_bank_ppc2simulink
// (NUM_REGS=4, register 0 self-clearing).
module tb_opb_register_bank_ppc2simulink;

  localparam int unsigned NR = 4;
  localparam logic [31:0] BASE = 32'h01010400;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [0:31]       abus;
  logic [0:3]        be;
  logic [0:31]       dbus;
  logic              rnw;
  logic              sel;
  logic              seq_addr;
  logic [0:31]       sl_dbus;
  logic              sl_ack, sl_err, sl_retry, sl_tout;
  logic [32*NR-1:0]  udata;
  logic [NR-1:0]     ustb;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .NUM_REGS       (NR),
    .C_SELFCLR_MASK (4'b0001)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst_n),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq_addr),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (sl_ack),
    .Sl_errAck     (sl_err),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_tout),
    .user_data_out (udata),
    .user_wr_stb   (ustb)
  );

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_ack;
    logic [31:0] exp_rd;
    logic [3:0]  exp_stb;
    int          ridx;
    logic [31:0] exp_reg1;
    logic [31:0] exp_reg2;
  } vec_t;

  function automatic logic [31:0] ureg(input int i);
    return udata[32*i +: 32];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer: accept cycle T, ack cycle T+1, idle cycle T+2.
  task automatic run_vec(input int n, input vec_t v);
    logic [31:0] rd;
    sel = 1'b1; rnw = v.rnw; abus = v.addr; be = v.be; dbus = v.wdata;
    @(negedge clk);
    chk($sformatf("v%0d ack_T", n), 32'(sl_ack), 32'd0);
    tick();
    sel = 1'b0; rnw = 1'b1; dbus = '0;
    @(negedge clk);
    rd = sl_dbus;
    chk($sformatf("v%0d ack_T1", n), 32'(sl_ack), 32'(v.exp_ack));
    chk($sformatf("v%0d rdata_T1", n), rd, v.exp_rd);
    chk($sformatf("v%0d stb_T1", n), 32'(ustb), 32'(v.exp_stb));
    chk($sformatf("v%0d reg%0d_T1", n, v.ridx), ureg(v.ridx), v.exp_reg1);
    tick();
    @(negedge clk);
    rd = sl_dbus;
    chk($sformatf("v%0d ack_T2", n), 32'(sl_ack), 32'd0);
    chk($sformatf("v%0d rdata_T2", n), rd, 32'd0);
    chk($sformatf("v%0d stb_T2", n), 32'(ustb), 32'd0);
    chk($sformatf("v%0d reg%0d_T2", n, v.ridx), ureg(v.ridx), v.exp_reg2);
    tick();
  endtask

  initial begin
    vec_t        vecs[14];
    logic [31:0] bdat[3];
    logic [6:0]  b2b_ack;
    logic [3:0]  b2b_stb[7];

    // rnw, addr, be, wdata, ack, rd, stb, ridx, reg@T+1, reg@T+2
    vecs[0]  = '{1'b1, 32'h01010404, 4'hF, 32'h0,        1'b1, 32'h0,        4'b0000, 1, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 32'h01010404, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        4'b0010, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h01010404, 4'hF, 32'h0,        1'b1, 32'hDEADBEEF, 4'b0000, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'h01010408, 4'hF, 32'h11223344, 1'b1, 32'h0,        4'b0100, 2, 32'h11223344, 32'h11223344};
    vecs[4]  = '{1'b0, 32'h01010408, 4'h5, 32'hAABBCCDD, 1'b1, 32'h0,        4'b0100, 2, 32'h11BB33DD, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 32'h0101040A, 4'hF, 32'h0,        1'b1, 32'h11BB33DD, 4'b0000, 2, 32'h11BB33DD, 32'h11BB33DD};
    vecs[6]  = '{1'b0, 32'h0101040C, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0,        4'b1000, 3, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 32'h01010410, 4'hF, 32'h12345678, 1'b1, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 32'h01010410, 4'hF, 32'h0,        1'b1, 32'h0,        4'b0000, 3, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 32'h01010500, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        4'b0000, 2, 32'h11BB33DD, 32'h11BB33DD};
    vecs[10] = '{1'b1, 32'h010104FC, 4'hF, 32'h0,        1'b1, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 32'h01010400, 4'hF, 32'h0,        1'b1, 32'h0,        4'b0000, 0, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 32'h01010400, 4'hF, 32'h00000001, 1'b1, 32'h0,        4'b0001, 0, 32'h1,        32'h0};
    vecs[13] = '{1'b1, 32'h010103FC, 4'hF, 32'h0,        1'b0, 32'h0,        4'b0000, 0, 32'h0,        32'h0};

    // Reset held with a pending write request
    rst_n = 1'b0; sel = 1'b1; rnw = 1'b0; abus = 32'h01010404; be = 4'hF;
    dbus = 32'hFFFFFFFF; seq_addr = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d ack", c), 32'(sl_ack), 32'd0);
      chk($sformatf("rst%0d stb", c), 32'(ustb), 32'd0);
      chk($sformatf("rst%0d dbus", c), sl_dbus, 32'd0);
      chk($sformatf("rst%0d udata_or", c), 32'(|udata), 32'd0);
      tick();
    end
    rst_n = 1'b1; sel = 1'b0; rnw = 1'b1;

    for (int n = 0; n < 14; n++) run_vec(n, vecs[n]);

    // Select held high for 6 cycles, address advanced after each accept
    bdat[0] = 32'h000000A0; bdat[1] = 32'h0000B0B1; bdat[2] = 32'h0000C0C2;
    b2b_ack = 7'b0101010;
    b2b_stb = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
    for (int c = 0; c < 7; c++) begin
      if (c < 6) begin
        sel = 1'b1; rnw = 1'b0; be = 4'hF;
        abus = BASE + 32'(4 * (c / 2));
        dbus = bdat[c / 2];
      end else begin
        sel = 1'b0; rnw = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("b2b c%0d ack", c), 32'(sl_ack), 32'(b2b_ack[6-c]));
      chk($sformatf("b2b c%0d stb", c), 32'(ustb), 32'(b2b_stb[c]));
      if (c == 1) chk("b2b reg0 pulse", ureg(0), 32'h000000A0);
      if (c == 2) chk("b2b reg0 cleared", ureg(0), 32'h0);
      tick();
    end
    chk("b2b reg1", ureg(1), 32'h0000B0B1);
    chk("b2b reg2", ureg(2), 32'h0000C0C2);

    // Reset asserted during the ack cycle of a self-clear write
    sel = 1'b1; rnw = 1'b0; abus = BASE; be = 4'hF; dbus = 32'h5;
    tick();
    sel = 1'b0; rnw = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("rstack ack_before_edge", 32'(sl_ack), 32'd1);
    chk("rstack reg0_before_edge", ureg(0), 32'h5);
    tick();
    @(negedge clk);
    chk("rstack ack", 32'(sl_ack), 32'd0);
    chk("rstack stb", 32'(ustb), 32'd0);
    chk("rstack reg0", ureg(0), 32'h0);
    chk("rstack reg1", ureg(1), 32'h0);
    tick();
    rst_n = 1'b1;

    // Reset asserted in the accept cycle suppresses the transfer
    sel = 1'b1; rnw = 1'b0; abus = BASE + 32'h4; be = 4'hF; dbus = 32'h77; rst_n = 1'b0;
    tick();
    sel = 1'b0; rnw = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    chk("rstacc ack", 32'(sl_ack), 32'd0);
    chk("rstacc stb", 32'(ustb), 32'd0);
    chk("rstacc reg1", ureg(1), 32'h0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised OPB slave exposing NUM_REGS software-writable 32-bit control registers to fabric logic. It is the multi-register successor of the single ppc2simulink register and adds byte-enable writes, readback, per-register write strobes and an optional self-clearing (pulse) mode. Everything runs on one clock domain (OPB_Clk), so there is no user_clk crossing.

Parameters:
C_BASEADDR, 32'h01010400, first byte address of the bank
C_HIGHADDR, 32'h010104FF, last byte address decoded by the block
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
NUM_REGS, 4, number of registers, 1..64, with 4*NUM_REGS <= C_HIGHADDR-C_BASEADDR+1
C_RESET_VAL, 32'h00000000, reset value of every register
C_SELFCLR_MASK, 0 (NUM_REGS bits), bit i set = register i self-clears

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst  in  1  synchronous reset, active-low (0 = reset)
OPB_ABus  in  [0:31]  byte address
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, zero when not acking
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
user_data_out  out  32*NUM_REGS  register i on bits [32i+31:32i]
user_wr_stb  out  NUM_REGS  one-cycle pulse, register i written

Behaviour:
- Reset (OPB_Rst=0 at a clock edge): all registers = C_RESET_VAL; Sl_xferAck=0; Sl_DBus=0; user_wr_stb=0. Reset overrides any in-flight transfer: no ack, no strobe, no write.
- Bit mapping: OPB DBus bit k corresponds to register bit 31-k. BE[0] enables register bits [31:24], BE[3] enables [7:0].
- Hit: OPB_select=1, C_BASEADDR <= ABus <= C_HIGHADDR, and Sl_xferAck=0 in that cycle.
- Index = (ABus - C_BASEADDR) >> 2. ABus[30:31] are ignored.
- Accept cycle T (hit) -> Sl_xferAck=1 during T+1 only. Latency is fixed at 1.
- A new hit cannot be accepted while Sl_xferAck=1. If select is held high continuously, acks occur every other cycle.
- Write, index < NUM_REGS: enabled bytes update at edge ending T. The new value is visible on user_data_out in T+1. user_wr_stb[index]=1 in T+1. With BE=0000, the value is unchanged but the strobe still fires.
- Write, index >= NUM_REGS (inside range): acked, no update, no strobe.
- Read: Sl_DBus = register[index] (bit-mapped) during T+1. For index >= NUM_REGS it is 0. Sl_DBus is 0 in every non-ack cycle.
- Reads do not affect registers or strobes.
- Self-clear (C_SELFCLR_MASK[i]=1): the register holds the written value for exactly one cycle (T+1) and returns to 0 at the next edge, unless a new write to it lands on that same edge, in which case the write wins. Readback of a self-clear register therefore returns 0 except in the cycle after a write.
- Address outside [C_BASEADDR, C_HIGHADDR]: ignored entirely, no ack.

Test Plan:
- Reset: hold OPB_Rst=0 for 3 cycles with select=1 -> xferAck=0, user_data_out all 0, user_wr_stb=0; after release, reads return 0.
- Full write and readback: write 32'hDEADBEEF to 0x01010404 with BE=1111 -> ack 1 cycle later for 1 cycle; reg1=DEADBEEF from T+1; user_wr_stb=0010 for 1 cycle; read 0x01010404 -> Sl_DBus=DEADBEEF during ack, 0 otherwise.
- Byte enables: reg2=0x11223344, then write 0xAABBCCDD with BE=0101 -> reg2=0x11BB33DD.
- Out-of-range index: write 0x01010410 (index 4, NUM_REGS=4) -> acked, no register change, no strobe; read there -> 0. Address 0x01010500 -> no ack.
- Back-to-back: select held high for 6 cycles over writes to regs 0..2 -> 3 acks on alternate cycles, each reg updated once.
- Self-clear (mask=0001): write 0x1 to reg0 -> user_data_out[31:0]=1 for exactly 1 cycle, then 0; reset asserted in the ack cycle -> ack dropped, reg0=0.
